// File: rtl/keypad_pkg.sv
// Shared key codes, direction constants, FSM states and the queued event format
// for the keypad event path.
package keypad_pkg;

    localparam logic [4:0] KEY_UP    = 5'b00001;
    localparam logic [4:0] KEY_DOWN  = 5'b01001;
    localparam logic [4:0] KEY_LEFT  = 5'b00100;
    localparam logic [4:0] KEY_RIGHT = 5'b00110;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        RPT  = 2'b10
    } kq_state_t;

    typedef struct packed {
        logic       rpt;
        logic       is_dir;
        logic [1:0] dir;
        logic [4:0] code;
    } key_evt_t;

    localparam int EVT_W = $bits(key_evt_t);

    // Arrow keys map to a direction; everything else is a plain key with dir 00.
    function automatic key_evt_t make_evt(input logic [4:0] code, input logic rpt);
        key_evt_t e;
        e.rpt    = rpt;
        e.code   = code;
        e.is_dir = 1'b1;
        e.dir    = DIR_UP;
        case (code)
            KEY_UP:    e.dir = DIR_UP;
            KEY_DOWN:  e.dir = DIR_DOWN;
            KEY_LEFT:  e.dir = DIR_LEFT;
            KEY_RIGHT: e.dir = DIR_RIGHT;
            default: begin
                e.is_dir = 1'b0;
                e.dir    = DIR_UP;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO: push/drop on the write side, valid/ready on the read side.
// Head data is read straight from storage and forced to zero when empty.
module evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && rd_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            overflow <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[AW-1:0]] <= push_data;
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/key_event_queue.sv
// Converts the scanner's level outputs into press/repeat events and queues them.
//   state | meaning
//   IDLE  | no key down; next registered key_ready starts a press
//   HOLD  | key held, timing the initial repeat delay
//   RPT   | key held past the first repeat, timing the repeat period
module key_event_queue
    import keypad_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_code,
    input  logic       key_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_code,
    output logic [1:0] evt_dir,
    output logic       evt_is_dir,
    output logic       evt_rpt,
    output logic       overflow
);

    localparam int MAX_DLY = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_DLY);
    localparam logic [CW-1:0] DLY_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_TC = CW'(REPEAT_PERIOD - 1);

    kq_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     code_lat_q, code_lat_d;
    logic [4:0]     key_code_q;
    logic           key_ready_q;
    logic [CW-1:0]  term_cnt;
    logic           push;
    logic           push_rpt;
    logic [EVT_W-1:0] push_data;
    logic [EVT_W-1:0] head_raw;
    key_evt_t       head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ready_q <= 1'b0;
            key_code_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_lat_q  <= '0;
        end else begin
            key_ready_q <= key_ready;
            key_code_q  <= key_code;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_lat_q  <= code_lat_d;
        end
    end

    assign term_cnt = (state_q == RPT) ? PER_TC : DLY_TC;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_lat_d = code_lat_q;
        push       = 1'b0;
        push_rpt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_ready_q) begin
                    push       = 1'b1;
                    code_lat_d = key_code_q;
                    state_d    = HOLD;
                end
            end
            HOLD, RPT: begin
                if (!key_ready_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (key_code_q != code_lat_q) begin
                    push       = 1'b1;
                    code_lat_d = key_code_q;
                    cnt_d      = '0;
                    state_d    = HOLD;
                end else if (cnt_q == term_cnt) begin
                    // With repeat disabled the counter parks at terminal count.
                    if (REPEAT_EN != 0) begin
                        push     = 1'b1;
                        push_rpt = 1'b1;
                        cnt_d    = '0;
                        state_d  = RPT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign push_data = make_evt(key_code_q, push_rpt);

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .rd_valid  (evt_valid),
        .rd_ready  (evt_ready),
        .rd_data   (head_raw),
        .overflow  (overflow)
    );

    assign head       = head_raw;
    assign evt_code   = head.code;
    assign evt_dir    = head.dir;
    assign evt_is_dir = head.is_dir;
    assign evt_rpt    = head.rpt;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: directed scenarios plus random key
// activity, compared every cycle against a timestamp/queue event model.
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int RDLY  = 8;
    localparam int RPER  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_code = '0;
    logic       key_ready = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [4:0] evt_code;
    logic [1:0] evt_dir;
    logic       evt_is_dir;
    logic       evt_rpt;
    logic       overflow;

    key_event_queue #(
        .DEPTH         (DEPTH),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_dir    (evt_dir),
        .evt_is_dir (evt_is_dir),
        .evt_rpt    (evt_rpt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic       rpt;
    } mev_t;

    mev_t       mq[$];
    logic       pin_rdy_prev = 1'b0;
    logic [4:0] pin_code_prev = '0;
    bit         m_active = 0;
    bit         m_rep = 0;
    logic [4:0] m_held = '0;
    int         m_last = 0;
    int         now = 0;
    bit         m_ovf = 0;
    int         errors = 0;
    int         checks = 0;
    int         ovf_seen = 0;
    int         rpt_seen = 0;

    function automatic logic [1:0] dir_of(input logic [4:0] c);
        case (c)
            5'b00001: return 2'b00;
            5'b01001: return 2'b01;
            5'b00100: return 2'b10;
            5'b00110: return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic is_dir_of(input logic [4:0] c);
        return (c == 5'b00001) || (c == 5'b01001) || (c == 5'b00100) || (c == 5'b00110);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event rules in terms of "time since last event" on the registered key inputs.
    task automatic model_edge();
        bit         ev;
        logic [4:0] ec;
        logic       er;
        ev = 0;
        ec = '0;
        er = 1'b0;
        now++;
        if (!m_active) begin
            if (pin_rdy_prev) begin
                ev = 1; ec = pin_code_prev; er = 1'b0;
                m_active = 1; m_rep = 0; m_held = ec; m_last = now;
            end
        end else if (!pin_rdy_prev) begin
            m_active = 0;
        end else if (pin_code_prev != m_held) begin
            ev = 1; ec = pin_code_prev; er = 1'b0;
            m_held = ec; m_rep = 0; m_last = now;
        end else if ((now - m_last) == (m_rep ? RPER : RDLY)) begin
            ev = 1; ec = m_held; er = 1'b1;
            m_rep = 1; m_last = now;
        end
        if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
        m_ovf = 0;
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back('{code: ec, rpt: er});
            else m_ovf = 1;
        end
        pin_rdy_prev  = key_ready;
        pin_code_prev = key_code;
    endtask

    task automatic check_out(input string tag);
        logic       ev_v;
        logic [4:0] ev_c;
        logic       ev_r;
        ev_v = (mq.size() > 0);
        ev_c = ev_v ? mq[0].code : 5'b0;
        ev_r = ev_v ? mq[0].rpt : 1'b0;
        chk({tag, ".valid"},  32'(evt_valid),  32'(ev_v));
        chk({tag, ".code"},   32'(evt_code),   32'(ev_c));
        chk({tag, ".dir"},    32'(evt_dir),    32'(ev_v ? dir_of(ev_c) : 2'b00));
        chk({tag, ".is_dir"}, 32'(evt_is_dir), 32'(ev_v ? is_dir_of(ev_c) : 1'b0));
        chk({tag, ".rpt"},    32'(evt_rpt),    32'(ev_r));
        chk({tag, ".ovf"},    32'(overflow),   32'(m_ovf));
    endtask

    task automatic step(input string tag, input logic r, input logic [4:0] c, input logic er);
        key_ready = r;
        key_code  = c;
        evt_ready = er;
        @(posedge clk);
        model_edge();
        #1;
        check_out(tag);
        if (overflow) ovf_seen++;
        if (evt_valid && evt_rpt && evt_ready) rpt_seen++;
    endtask

    task automatic press(input string tag, input logic [4:0] c, input logic er);
        step(tag, 1'b1, c, er);
        step(tag, 1'b1, c, er);
        step(tag, 1'b0, 5'b0, er);
        step(tag, 1'b0, 5'b0, er);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, ".valid"},  32'(evt_valid),  32'(0));
        chk({tag, ".code"},   32'(evt_code),   32'(0));
        chk({tag, ".dir"},    32'(evt_dir),    32'(0));
        chk({tag, ".is_dir"}, 32'(evt_is_dir), 32'(0));
        chk({tag, ".rpt"},    32'(evt_rpt),    32'(0));
        chk({tag, ".ovf"},    32'(overflow),   32'(0));
    endtask

    initial begin
        int         n;
        int         mode;
        logic [4:0] rc;

        repeat (2) @(posedge clk);
        #1;
        zero_outputs("reset");
        #2 rst_n = 1'b1;

        // Single short press of UP.
        repeat (3) step("idle", 1'b0, 5'b0, 1'b1);
        repeat (3) step("up_press", 1'b1, 5'b00001, 1'b1);
        repeat (12) step("up_rel", 1'b0, 5'b0, 1'b1);

        // RIGHT held for 20 cycles: one press then three repeats.
        rpt_seen = 0;
        repeat (20) step("right_hold", 1'b1, 5'b00110, 1'b1);
        repeat (12) step("right_rel", 1'b0, 5'b0, 1'b1);
        chk("right_repeats", 32'(rpt_seen), 32'(3));

        // Five presses with no consumer: fifth one overflows.
        ovf_seen = 0;
        press("fill1", 5'b00001, 1'b0);
        press("fill2", 5'b01001, 1'b0);
        press("fill3", 5'b00100, 1'b0);
        press("fill4", 5'b00110, 1'b0);
        press("fill5", 5'b11111, 1'b0);
        chk("overflow_pulses", 32'(ovf_seen), 32'(1));
        repeat (6) step("drain", 1'b0, 5'b0, 1'b1);

        // Full FIFO with simultaneous push and pop.
        ovf_seen = 0;
        press("pf1", 5'b00010, 1'b0);
        press("pf2", 5'b00011, 1'b0);
        press("pf3", 5'b00101, 1'b0);
        press("pf4", 5'b00111, 1'b0);
        step("pushpop", 1'b1, 5'b01000, 1'b0);
        step("pushpop", 1'b1, 5'b01000, 1'b1);
        step("pushpop", 1'b0, 5'b0, 1'b0);
        chk("pushpop_no_ovf", 32'(ovf_seen), 32'(0));
        chk("pushpop_count", 32'(mq.size()), 32'(4));
        repeat (6) step("pp_drain", 1'b0, 5'b0, 1'b1);

        // LEFT held, then switched to a non-arrow code without release.
        repeat (5) step("left_hold", 1'b1, 5'b00100, 1'b1);
        repeat (14) step("switch", 1'b1, 5'b10011, 1'b1);
        repeat (4) step("switch_rel", 1'b0, 5'b0, 1'b1);

        // Reset with two events queued and a key held.
        press("pre_rst", 5'b00001, 1'b0);
        repeat (3) step("pre_rst_hold", 1'b1, 5'b00110, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        zero_outputs("mid_reset");
        mq.delete();
        m_active      = 0;
        m_ovf         = 0;
        pin_rdy_prev  = 1'b0;
        pin_code_prev = '0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (4) step("post_rst", 1'b1, 5'b00110, 1'b0);
        chk("post_rst_count", 32'(mq.size()), 32'(1));
        repeat (4) step("post_rst_rel", 1'b0, 5'b0, 1'b1);

        // Random key activity and consumer back-pressure.
        repeat (40) begin
            n    = $urandom_range(1, 20);
            mode = $urandom_range(0, 5);
            case (mode)
                0: rc = 5'b00001;
                1: rc = 5'b01001;
                2: rc = 5'b00100;
                3: rc = 5'b00110;
                default: rc = 5'($urandom_range(0, 31));
            endcase
            for (int i = 0; i < n; i++) begin
                if (mode == 5) step("rnd", 1'b0, 5'b0, 1'($urandom_range(0, 3) != 0));
                else           step("rnd", 1'b1, rc,   1'($urandom_range(0, 3) != 0));
            end
        end
        repeat (8) step("final_drain", 1'b0, 5'b0, 1'b1);
        chk("final_empty", 32'(evt_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
